// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: two-requester round-robin arbiter with bounded burst
// locking in front of a single synchronous BRAM port. Grants at most one
// access per cycle, drives the BRAM port combinationally from the winner,
// and returns read data (or a write ack) tagged with the requester id after
// RD_LAT cycles.
//
// Handshake: req_valid[i] must not depend on req_ready[i]; a request is
// accepted in the cycle where req_valid[i] & req_ready[i] is high, and its
// response strobe rsp_valid[i] rises exactly RD_LAT cycles later. There is no
// response backpressure.
module bram_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [1:0]          req_lock,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_wdata,
  output logic                bram_we,
  output logic                bram_clken,
  input  logic [DATA_W-1:0]   bram_rdata
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  // Arbitration state
  logic             last_grant;
  logic             lock_q;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_next;

  // Held BRAM address/data for cycles without a grant
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Winner selection
  logic              winner;
  logic [1:0]        grant;
  logic              any_grant;
  logic              burst_full;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  // Response pipeline, stage 1 is loaded at the accepting edge
  logic [RD_LAT:1] pipe_v;
  logic [RD_LAT:1] pipe_id;
  logic [RD_LAT:1] pipe_we;
  logic            rsp_fire;

  // Combinational arbitration: single requester always wins; on a tie the
  // locked requester keeps priority until its burst quota is used up,
  // otherwise the requester not served last wins. Nothing is granted in a
  // reset cycle.
  always_comb begin
    grant      = 2'b00;
    winner     = 1'b0;
    burst_full = (burst_cnt >= MAX_CNT);
    if (!rst) begin
      case (req_valid)
        2'b01: begin
          winner = 1'b0;
          grant  = 2'b01;
        end
        2'b10: begin
          winner = 1'b1;
          grant  = 2'b10;
        end
        2'b11: begin
          if (lock_q && !burst_full) begin
            winner = last_grant;
          end else begin
            winner = ~last_grant;
          end
          grant = winner ? 2'b10 : 2'b01;
        end
        default: begin
          grant  = 2'b00;
          winner = 1'b0;
        end
      endcase
    end
  end

  // Winner's request fields and the BRAM port drive
  always_comb begin
    any_grant  = |grant;
    sel_addr   = winner ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
    sel_wdata  = winner ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    sel_we     = winner ? req_we[1] : req_we[0];
    req_ready  = grant;
    bram_clken = any_grant;
    bram_we    = any_grant & sel_we;
    bram_addr  = any_grant ? sel_addr  : addr_q;
    bram_wdata = any_grant ? sel_wdata : wdata_q;
  end

  // Burst counter next value: consecutive grants to the same requester count
  // up and saturate at MAX_BURST; a new owner restarts the count at 1.
  always_comb begin
    burst_next = '0;
    if (any_grant) begin
      if ((winner == last_grant) && (burst_cnt != '0)) begin
        burst_next = burst_full ? MAX_CNT : (burst_cnt + CNT_W'(1));
      end else begin
        burst_next = CNT_W'(1);
      end
    end
  end

  // Arbitration state and held port values; an idle cycle ends any burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      lock_q     <= 1'b0;
      burst_cnt  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (any_grant) begin
      last_grant <= winner;
      lock_q     <= winner ? req_lock[1] : req_lock[0];
      burst_cnt  <= burst_next;
      addr_q     <= sel_addr;
      wdata_q    <= sel_wdata;
    end else begin
      lock_q     <= 1'b0;
      burst_cnt  <= '0;
    end
  end

  // Response tag pipeline matching the BRAM read latency; reset drops
  // everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v  <= '0;
      pipe_id <= '0;
      pipe_we <= '0;
    end else begin
      pipe_v[1]  <= any_grant;
      pipe_id[1] <= winner;
      pipe_we[1] <= bram_we;
      for (int k = 2; k <= RD_LAT; k++) begin
        pipe_v[k]  <= pipe_v[k-1];
        pipe_id[k] <= pipe_id[k-1];
        pipe_we[k] <= pipe_we[k-1];
      end
    end
  end

  // Response outputs: strobe to the tagged requester, data zeroed for acks.
  always_comb begin
    rsp_fire  = pipe_v[RD_LAT] & ~rst;
    rsp_valid = 2'b00;
    rsp_data  = '0;
    if (rsp_fire) begin
      rsp_valid = pipe_id[RD_LAT] ? 2'b10 : 2'b01;
      if (!pipe_we[RD_LAT]) begin
        rsp_data = bram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: table of per-cycle vectors against an
// RD_LAT=1 instance, plus hand sequences for latency and reset-mid-flight
// on an RD_LAT=2 instance. Memories are preloaded with mem[a] = a[7:0]^8'hA0.
module tb_bram_port_arbiter;

  typedef struct {
    logic        r;
    logic [1:0]  v;
    logic [1:0]  we;
    logic [1:0]  lk;
    logic [11:0] a0;
    logic [11:0] a1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [1:0]  e_rdy;
    logic        e_clk;
    logic        e_we;
    logic [11:0] e_addr;
    logic [1:0]  e_rv;
    logic [7:0]  e_rd;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Clock / reset and shared stimulus
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we, req_lock;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;

  always #5 clk = ~clk;

  // Instance 1: RD_LAT = 1
  logic [1:0]  ready1, rv1;
  logic [7:0]  rd1, bwd1, brd1;
  logic [11:0] baddr1;
  logic        bwe1, bclk1;

  bram_port_arbiter #(.ADDR_W(12), .DATA_W(8), .RD_LAT(1), .MAX_BURST(4)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
    .req_we(req_we), .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_data(rd1), .bram_addr(baddr1), .bram_wdata(bwd1),
    .bram_we(bwe1), .bram_clken(bclk1), .bram_rdata(brd1)
  );

  // Instance 2: RD_LAT = 2
  logic [1:0]  ready2, rv2;
  logic [7:0]  rd2, bwd2, brd2;
  logic [11:0] baddr2;
  logic        bwe2, bclk2;

  bram_port_arbiter #(.ADDR_W(12), .DATA_W(8), .RD_LAT(2), .MAX_BURST(4)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready2),
    .req_we(req_we), .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_data(rd2), .bram_addr(baddr2), .bram_wdata(bwd2),
    .bram_we(bwe2), .bram_clken(bclk2), .bram_rdata(brd2)
  );

  // BRAM models
  logic [7:0] mem1 [4096];
  logic [7:0] mem2 [4096];
  logic [7:0] r2a;

  always @(posedge clk) begin
    if (bclk1) begin
      if (bwe1) mem1[baddr1] = bwd1;
      else      brd1 <= mem1[baddr1];
    end
  end

  always @(posedge clk) begin
    if (bclk2) begin
      if (bwe2) mem2[baddr2] = bwd2;
      else      r2a <= mem2[baddr2];
    end
    brd2 <= r2a;
  end

  // Scoreboard compare
  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0h want %0h", nm, row, act, exp);
    end
  endtask

  // Driver
  task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] we,
                       input logic [1:0] lk, input logic [11:0] a0, input logic [11:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    rst       = r;
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [1:0] we,
                              input logic [1:0] lk, input logic [11:0] a0, input logic [11:0] a1,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [1:0] e_rdy, input logic e_clk, input logic e_we,
                              input logic [11:0] e_addr, input logic [1:0] e_rv,
                              input logic [7:0] e_rd);
    vec_t t;
    t.r = r; t.v = v; t.we = we; t.lk = lk; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.e_rdy = e_rdy; t.e_clk = e_clk; t.e_we = e_we; t.e_addr = e_addr;
    t.e_rv = e_rv; t.e_rd = e_rd;
    return t;
  endfunction

  vec_t vecs[$];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem1[i] = 8'(i) ^ 8'hA0;
      mem2[i] = 8'(i) ^ 8'hA0;
    end
    brd1 = 8'h00;
    brd2 = 8'h00;
    r2a  = 8'h00;

    // Reset held 3 cycles with both requesters valid
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 12'h005, 12'h010, 8'h00, 8'h00, 2'b00, 0, 0, 12'h000, 2'b00, 8'h00));
    // Contention, no lock: first tie to 0, then alternating
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 12'h005, 12'h010, 8'h00, 8'h00, 2'b01, 1, 0, 12'h005, 2'b00, 8'h00));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 12'h010, 12'h020, 8'h00, 8'h00, 2'b10, 1, 0, 12'h020, 2'b01, 8'hA5));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 12'h031, 12'h042, 8'h00, 8'h00, 2'b01, 1, 0, 12'h031, 2'b10, 8'h80));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 12'h053, 12'h005, 8'h00, 8'h00, 2'b10, 1, 0, 12'h005, 2'b01, 8'h91));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 12'h010, 12'h020, 8'h00, 8'h00, 2'b01, 1, 0, 12'h010, 2'b10, 8'hA5));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 12'h031, 12'h042, 8'h00, 8'h00, 2'b10, 1, 0, 12'h042, 2'b01, 8'hB0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00, 2'b00, 0, 0, 12'h042, 2'b10, 8'hE2));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00, 2'b00, 0, 0, 12'h042, 2'b00, 8'h00));
    // Single read by requester 0
    vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 12'h005, 12'h000, 8'h00, 8'h00, 2'b01, 1, 0, 12'h005, 2'b00, 8'h00));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00, 2'b00, 0, 0, 12'h005, 2'b01, 8'hA5));
    // Write then read, requester 1
    vecs.push_back(mk(0, 2'b10, 2'b10, 2'b00, 12'h000, 12'h123, 8'h00, 8'h3C, 2'b10, 1, 1, 12'h123, 2'b00, 8'h00));
    vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, 12'h000, 12'h123, 8'h00, 8'h00, 2'b10, 1, 0, 12'h123, 2'b10, 8'h00));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00, 2'b00, 0, 0, 12'h123, 2'b10, 8'h3C));
    // Reset cycle: address still held, nothing granted
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00, 2'b00, 0, 0, 12'h123, 2'b00, 8'h00));
    // Burst lock by requester 1 while requester 0 waits: 1,1,1,1,0,1,1,1,1,0
    vecs.push_back(mk(0, 2'b10, 2'b00, 2'b10, 12'h000, 12'h010, 8'h00, 8'h00, 2'b10, 1, 0, 12'h010, 2'b00, 8'h00));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 12'h020, 12'h031, 8'h00, 8'h00, 2'b10, 1, 0, 12'h031, 2'b10, 8'hB0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 12'h020, 12'h042, 8'h00, 8'h00, 2'b10, 1, 0, 12'h042, 2'b10, 8'h91));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 12'h020, 12'h053, 8'h00, 8'h00, 2'b10, 1, 0, 12'h053, 2'b10, 8'hE2));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 12'h020, 12'h005, 8'h00, 8'h00, 2'b01, 1, 0, 12'h020, 2'b10, 8'hF3));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 12'h031, 12'h010, 8'h00, 8'h00, 2'b10, 1, 0, 12'h010, 2'b01, 8'h80));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 12'h031, 12'h020, 8'h00, 8'h00, 2'b10, 1, 0, 12'h020, 2'b10, 8'hB0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 12'h031, 12'h031, 8'h00, 8'h00, 2'b10, 1, 0, 12'h031, 2'b10, 8'h80));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 12'h031, 12'h042, 8'h00, 8'h00, 2'b10, 1, 0, 12'h042, 2'b10, 8'h91));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 12'h053, 12'h005, 8'h00, 8'h00, 2'b01, 1, 0, 12'h053, 2'b10, 8'hE2));
    // Locked requester 1 alone: 10 grants, count saturates, then yields
    vecs.push_back(mk(0, 2'b10, 2'b00, 2'b10, 12'h000, 12'h005, 8'h00, 8'h00, 2'b10, 1, 0, 12'h005, 2'b01, 8'hF3));
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(0, 2'b10, 2'b00, 2'b10, 12'h000, 12'h005, 8'h00, 8'h00, 2'b10, 1, 0, 12'h005, 2'b10, 8'hA5));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 12'h010, 12'h005, 8'h00, 8'h00, 2'b01, 1, 0, 12'h010, 2'b10, 8'hA5));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00, 2'b00, 0, 0, 12'h010, 2'b01, 8'hB0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00, 2'b00, 0, 0, 12'h010, 2'b00, 8'h00));

    // Initial reset edge (unchecked: registers not yet initialised)
    drive(1, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00);
    @(negedge clk);

    // Table-driven section, instance 1
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].r, vecs[i].v, vecs[i].we, vecs[i].lk, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      #1;
      chk("req_ready",  i, 32'(ready1), 32'(vecs[i].e_rdy));
      chk("bram_clken", i, 32'(bclk1),  32'(vecs[i].e_clk));
      chk("bram_we",    i, 32'(bwe1),   32'(vecs[i].e_we));
      chk("bram_addr",  i, 32'(baddr1), 32'(vecs[i].e_addr));
      chk("rsp_valid",  i, 32'(rv1),    32'(vecs[i].e_rv));
      chk("rsp_data",   i, 32'(rd1),    32'(vecs[i].e_rd));
    end

    // RD_LAT = 2: read latency on instance 2
    @(negedge clk);
    drive(1, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00);
    @(negedge clk);
    drive(0, 2'b01, 2'b00, 2'b00, 12'h005, 12'h000, 8'h00, 8'h00);
    #1;
    chk("lat2_ready", 100, 32'(ready2), 32'(2'b01));
    chk("lat2_addr",  100, 32'(baddr2), 32'(12'h005));
    @(negedge clk);
    drive(0, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00);
    #1;
    chk("lat2_rv_n1", 101, 32'(rv2), 32'(2'b00));
    @(negedge clk);
    #1;
    chk("lat2_rv_n2", 102, 32'(rv2), 32'(2'b01));
    chk("lat2_rd_n2", 102, 32'(rd2), 32'(8'hA5));

    // RD_LAT = 2: reset one cycle after acceptance drops the response
    @(negedge clk);
    drive(0, 2'b01, 2'b00, 2'b00, 12'h010, 12'h000, 8'h00, 8'h00);
    #1;
    chk("mid_ready_n", 110, 32'(ready2), 32'(2'b01));
    @(negedge clk);
    drive(1, 2'b11, 2'b00, 2'b00, 12'h020, 12'h031, 8'h00, 8'h00);
    #1;
    chk("mid_ready_rst", 111, 32'(ready2), 32'(2'b00));
    chk("mid_clken_rst", 111, 32'(bclk2),  32'(1'b0));
    chk("mid_rv_rst",    111, 32'(rv2),    32'(2'b00));
    @(negedge clk);
    drive(0, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00);
    #1;
    chk("mid_rv_n2",    112, 32'(rv2),    32'(2'b00));
    chk("mid_rd_n2",    112, 32'(rd2),    32'(8'h00));
    chk("mid_ready_n2", 112, 32'(ready2), 32'(2'b00));
    chk("mid_clken_n2", 112, 32'(bclk2),  32'(1'b0));
    chk("mid_we_n2",    112, 32'(bwe2),   32'(1'b0));
    chk("mid_addr_n2",  112, 32'(baddr2), 32'(12'h000));
    chk("mid_wdata_n2", 112, 32'(bwd2),   32'(8'h00));
    @(negedge clk);
    #1;
    chk("mid_rv_n3",    113, 32'(rv2),    32'(2'b00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
